pipe_skid_reg: RTL and testbench
================================

// Module: pipe_skid_reg
// PURPOSE
//  Elastic pipeline register: a 64-bit valid/ready stage with a 2-entry skid buffer.
//  Sits between datapath stages and replaces a bare enable-flop when the consumer can stall.
//  Full throughput (1 beat/cycle) and 1-cycle latency. in_ready is driven only from flops,
//  so there is no combinational path from out_ready to in_ready.
// PARAMETERS
//  WIDTH      64  payload width in bits
//  RESET_VAL  0   value of both data registers (and so out_data) after reset
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  rst        in   1      asynchronous, active-low reset (0 = reset asserted)
//  flush      in   1      synchronous discard of all held beats
//  in_valid   in   1      upstream beat present
//  in_ready   out  1      stage can accept a beat this cycle
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      beat presented downstream
//  out_ready  in   1      downstream accepts this cycle
//  out_data   out  WIDTH  downstream payload
// BEHAVIOUR
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready (both sampled at posedge).
//  - Reset (rst=0, async): state=EMPTY, main=skid=RESET_VAL, out_valid=0, in_ready=0 while
//    rst=0. in_ready=1 from the first edge after rst deasserts.
//  - State is EMPTY / ONE / FULL, counting beats held (main reg, then main+skid).
//  - Outputs: out_valid=(state!=EMPTY); out_data=main; in_ready=(state!=FULL) & rst.
//  - Transitions:
//      EMPTY: in_fire -> ONE, main<=in_data.
//      ONE: in_fire & out_fire -> ONE, main<=in_data.
//           in_fire & !out_fire -> FULL, skid<=in_data.
//           !in_fire & out_fire -> EMPTY.
//           Otherwise hold.
//      FULL: in_ready=0. out_fire -> ONE, main<=skid. Otherwise hold.
//  - Latency: a beat accepted at edge N is on out_data/out_valid after edge N (visible in
//    cycle N+1).
//  - Ordering is strictly FIFO. No beat is ever duplicated or dropped, except by flush.
//  - While out_valid=1 & out_ready=0, out_data is stable (AXI-style hold rule).
//  - flush=1 has the highest priority: next state EMPTY, and any beat accepted or presented
//    in the flush cycle is discarded. Data regs keep their old contents; only the valid state
//    clears.
//  - flush while FULL: in_ready returns to 1 the next cycle.
//  - Reset mid-transfer: all beats are lost immediately. out_valid falls asynchronously;
//    no clock is needed.
//  - Illegal state encoding, if reached: next state EMPTY.
// STRUCTURE
//  - Package pipe_pkg:
//      typedef enum logic [1:0] {ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2} skid_state_t;
//      localparam PIPE_W = 64 (default payload width shared by the stages).
//  - Sub-module reg_async_n #(WIDTH, RESET_VAL) (clk, rst, din, dout, wen):
//      - enable flop, asynchronous active-low reset;
//      - instantiated twice: main and skid;
//      - state flop written inline.
//  - Next-state/enable logic in one always_comb block; outputs decoded from state only.
// TESTING
//  1. Reset: rst=0 mid-sim, out_valid=1 -> out_valid=0, out_data=0, in_ready=0 immediately.
//     Release -> in_ready=1 at the next edge.
//  2. Streaming: out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles ->
//     out_data 1,2,3,4 one cycle later; in_ready stays 1 throughout.
//  3. Backpressure: send 0xA,0xB with out_ready=0 -> state FULL, in_ready=0, out_data=0xA
//     stable. Raise out_ready -> 0xA then 0xB; in_ready=1 one cycle after 0xA leaves.
//  4. Simultaneous: in state ONE holding 0x5, in_fire(0x6) & out_fire in the same cycle ->
//     state ONE, out_data=0x6, no bubble.
//  5. Flush in FULL with in_valid=1 (0xC) -> next cycle out_valid=0, in_ready=1. 0xC is
//     never emitted.
//  6. Random valid/ready, 10k beats vs. scoreboard queue -> zero mismatches. Assert that
//     out_data is stable while out_valid & !out_ready.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline stages.
package pipe_pkg;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    localparam int PIPE_W = 64;
endpackage

// File: rtl/reg_async_n.sv
// Purpose: write-enabled data register with asynchronous active-low reset.
// Latency: 1 cycle from wen to dout.
// Backpressure: none; the owner gates wen.
module reg_async_n #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end
endmodule

// File: rtl/pipe_skid_reg.sv
// Purpose: elastic valid/ready pipeline register with a 2-entry skid buffer.
// Latency: 1 cycle, full throughput.
// Backpressure: in_ready comes only from state (no out_ready->in_ready path).
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = PIPE_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    skid_state_t      state;
    skid_state_t      state_nxt;
    logic             main_wen;
    logic             skid_wen;
    logic [WIDTH-1:0] main_din;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;

    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = (state != ST_FULL) & rst;
    assign out_data  = main_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        main_wen  = 1'b0;
        skid_wen  = 1'b0;
        main_din  = in_data;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_nxt = ST_ONE;
                    main_wen  = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_wen = 1'b1;
                end else if (in_fire) begin
                    state_nxt = ST_FULL;
                    skid_wen  = 1'b1;
                end else if (out_fire) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_nxt = ST_ONE;
                    main_wen  = 1'b1;
                    main_din  = skid_q;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // Flush only clears occupancy; data registers keep their contents.
        if (flush) begin
            state_nxt = ST_EMPTY;
            main_wen  = 1'b0;
            skid_wen  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    reg_async_n #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clk  (clk),
        .rst  (rst),
        .din  (main_din),
        .dout (main_q),
        .wen  (main_wen)
    );

    reg_async_n #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .din  (in_data),
        .dout (skid_q),
        .wen  (skid_wen)
    );
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vectors plus a random stream against a FIFO scoreboard.
module tb_pipe_skid_reg;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    int tests = 0;
    int fails = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(64), .RESET_VAL(64'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pushes accepted beats, pops and compares emitted beats.
    task automatic monitor();
        logic        prev_hold = 1'b0;
        logic [63:0] prev_dat  = '0;
        logic [63:0] exp;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sb.delete();
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) chk("hold_stable", out_data, prev_dat);
                if (flush) begin
                    sb.delete();
                end else begin
                    if (out_valid && out_ready) begin
                        if (sb.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL sb_unexpected: got 0x%0h, expected no beat", out_data);
                        end else begin
                            exp = sb.pop_front();
                            chk("sb_data", out_data, exp);
                        end
                    end
                    if (in_valid && in_ready) sb.push_back(in_data);
                end
                prev_hold = out_valid && !out_ready;
                prev_dat  = out_data;
            end
        end
    endtask

    initial begin
        int sent;
        int cyc;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        fork
            monitor();
        join_none

        #3;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        step();
        rst = 1'b1;
        step();
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

        // Streaming
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 64'(i);
            step();
            chk("stream_data", out_data, 64'(i));
            chk("stream_valid", {63'd0, out_valid}, 64'd1);
            chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drained", {63'd0, out_valid}, 64'd0);

        // Backpressure into FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA;
        step();
        in_data = 64'hB;
        step();
        in_valid = 1'b0;
        chk("bp_in_ready_full", {63'd0, in_ready}, 64'd0);
        chk("bp_data_a", out_data, 64'hA);
        step();
        chk("bp_data_a_held", out_data, 64'hA);
        out_ready = 1'b1;
        step();
        chk("bp_data_b", out_data, 64'hB);
        chk("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
        step();
        chk("bp_drained", {63'd0, out_valid}, 64'd0);

        // Simultaneous in/out fire in ONE
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h5;
        step();
        chk("sim_data_5", out_data, 64'h5);
        in_data   = 64'h6;
        out_ready = 1'b1;
        step();
        chk("sim_data_6", out_data, 64'h6);
        chk("sim_valid", {63'd0, out_valid}, 64'd1);
        chk("sim_in_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b0;
        step();

        // Flush while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h11;
        step();
        in_data = 64'h22;
        step();
        chk("fl_full", {63'd0, in_ready}, 64'd0);
        in_data = 64'hC;
        flush   = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        step();
        chk("fl_no_c", {63'd0, out_valid}, 64'd0);
        in_valid = 1'b1;
        in_data  = 64'h33;
        step();
        in_valid = 1'b0;
        chk("fl_after_data", out_data, 64'h33);
        step();

        // Asynchronous reset mid-transfer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h77;
        step();
        in_valid = 1'b0;
        chk("ar_loaded", {63'd0, out_valid}, 64'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("ar_out_valid", {63'd0, out_valid}, 64'd0);
        chk("ar_out_data", out_data, 64'd0);
        chk("ar_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        rst = 1'b1;
        step();
        chk("ar_rel_in_ready", {63'd0, in_ready}, 64'd1);
        chk("ar_rel_out_valid", {63'd0, out_valid}, 64'd0);

        // Random stream
        sent = 0;
        cyc  = 0;
        while (sent < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            in_data   = {$urandom(), $urandom()};
            if (in_valid && in_ready) sent++;
            step();
            cyc++;
        end
        chk("rand_beats_sent", 64'(sent), 64'd10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while ((out_valid || sb.size() != 0) && cyc < 20) begin
            step();
            cyc++;
        end
        @(negedge clk);
        #1;
        chk("rand_sb_empty", 64'(sb.size()), 64'd0);
        chk("rand_out_idle", {63'd0, out_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
